vga_tile_scanout: RTL



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_tile_scanout_if.sv | 15 +
 rtl/vga_tile_ram.sv | 29 ++
 rtl/vga_tile_scanout.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 1280x800@60 timing constants, the packed pixel type and
// the test-pattern selector encoding shared by the tile scan-out block.
package vga_pkg;

  localparam int DEF_H_ACTIVE   = 1280;
  localparam int DEF_H_FP       = 64;
  localparam int DEF_H_SYNC     = 136;
  localparam int DEF_H_BP       = 200;
  localparam int DEF_V_ACTIVE   = 800;
  localparam int DEF_V_FP       = 1;
  localparam int DEF_V_SYNC     = 3;
  localparam int DEF_V_BP       = 24;
  localparam bit DEF_HSYNC_POL  = 1'b0;
  localparam bit DEF_VSYNC_POL  = 1'b1;
  localparam int DEF_SCALE_LOG2 = 3;
  localparam int DEF_PIX_W      = 15;
  localparam int DEF_CH_W       = DEF_PIX_W / 3;

  // Packed pixel at the default width: red in the top third, blue in the bottom.
  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } pixel_t;

  // Source selection when the built-in test pattern generator is compiled in.
  typedef enum logic [1:0] {
    PAT_BUFFER    = 2'd0,
    PAT_RED_GREEN = 2'd1,
    PAT_RED_BLUE  = 2'd2,
    PAT_WHITE     = 2'd3
  } pattern_e;

endpackage

// File: rtl/vga_tile_scanout_if.sv
// vga_tile_scanout_if: host-side tile write bus. The host drives the master
// modport; the scan-out block receives through the slave modport.
interface vga_tile_scanout_if #(
  parameter int TX_W  = 8,
  parameter int TY_W  = 7,
  parameter int PIX_W = 15
);
  logic             wr_en;
  logic [TX_W-1:0]  wr_x;
  logic [TY_W-1:0]  wr_y;
  logic [PIX_W-1:0] wr_data;

  modport master (output wr_en, output wr_x, output wr_y, output wr_data);
  modport slave  (input  wr_en, input  wr_x, input  wr_y, input  wr_data);
endinterface

// File: rtl/vga_tile_ram.sv
// vga_tile_ram: simple dual-port tile store, one write port and one registered
// read port. A read and a write to the same word in one cycle return the old word.
module vga_tile_ram #(
  parameter int DATA_W = 15,
  parameter int DEPTH  = 16000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              pixel_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Write and registered read share one process so the read samples the pre-write word.
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: raster timing generator that scans a tile buffer out as
// upscaled VGA pixels through a fixed two-stage pipeline (S0 counters, S1 RAM
// read, S2 output registers). Defining VGA_TEST_PATTERN_EN adds pattern_sel
// and a built-in test pattern generator in front of the output stage.
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = DEF_HSYNC_POL,
  parameter bit VSYNC_POL  = DEF_VSYNC_POL,
  parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic                 pixel_clk,
  input  logic                 rst_n,
  vga_tile_scanout_if.slave    wr,
`ifdef VGA_TEST_PATTERN_EN
  input  logic [1:0]           pattern_sel,
`endif
  output logic [PIX_W/3-1:0]   vr,
  output logic [PIX_W/3-1:0]   vg,
  output logic [PIX_W/3-1:0]   vb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic                 frame_start
);

  localparam int          CH_W      = PIX_W / 3;
  localparam int          H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HPOS_W    = $clog2(H_TOTAL);
  localparam int          VPOS_W    = $clog2(V_TOTAL);
  localparam int unsigned TILES_X   = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned TILES_Y   = V_ACTIVE >> SCALE_LOG2;
  localparam int          DEPTH     = TILES_X * TILES_Y;
  localparam int          ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned H_ACT_U   = H_ACTIVE;
  localparam int unsigned V_ACT_U   = V_ACTIVE;
  localparam int unsigned HS_START  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

  logic [HPOS_W-1:0] hpos_reg, hpos_next;
  logic [VPOS_W-1:0] vpos_reg, vpos_next;
  logic              hsync_s0, vsync_s0, blank_s0, fs_s0;
  logic              hsync_s1_reg, vsync_s1_reg, blank_s1_reg, fs_s1_reg;
  logic              hsync_reg, vsync_reg, blank_reg, fs_reg;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              wr_accept;
  logic [PIX_W-1:0]  ram_rd_data;
  logic [PIX_W-1:0]  pix_s1;

  // Raster counters: hpos sweeps the line, vpos steps once per line wrap.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_reg <= '0;
      vpos_reg <= '0;
    end else begin
      hpos_reg <= hpos_next;
      vpos_reg <= vpos_next;
    end
  end

  // Next raster position with wrap at the end of line and end of frame.
  always_comb begin
    hpos_next = hpos_reg + 1'b1;
    vpos_next = vpos_reg;
    if (hpos_reg == HPOS_W'(H_TOTAL - 1)) begin
      hpos_next = '0;
      vpos_next = (vpos_reg == VPOS_W'(V_TOTAL - 1)) ? '0 : vpos_reg + 1'b1;
    end
  end

  // Stage-0 timing decode straight from the counters.
  always_comb begin
    hsync_s0 = ((32'(hpos_reg) >= HS_START) && (32'(hpos_reg) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_s0 = ((32'(vpos_reg) >= VS_START) && (32'(vpos_reg) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    blank_s0 = (32'(hpos_reg) >= H_ACT_U) || (32'(vpos_reg) >= V_ACT_U);
    fs_s0    = (hpos_reg == '0) && (vpos_reg == '0);
  end

  // Tile addressing is row-major; blanked positions read word 0 since their data is discarded.
  assign rd_addr = blank_s0 ? '0 :
                   ADDR_W'(((32'(vpos_reg) >> SCALE_LOG2) * TILES_X) + (32'(hpos_reg) >> SCALE_LOG2));

  // Out-of-range coordinates are dropped rather than folded into another tile.
  assign wr_accept = wr.wr_en && (32'(wr.wr_x) < TILES_X) && (32'(wr.wr_y) < TILES_Y);
  assign wr_addr   = ADDR_W'((32'(wr.wr_y) * TILES_X) + 32'(wr.wr_x));

  vga_tile_ram #(
    .DATA_W (PIX_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tile_ram (
    .pixel_clk (pixel_clk),
    .wr_en     (wr_accept),
    .wr_addr   (wr_addr),
    .wr_data   (wr.wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (ram_rd_data)
  );

  // Stage-1 control delay, keeping sync/blank/frame_start level with the RAM read.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_s1_reg <= ~HSYNC_POL;
      vsync_s1_reg <= ~VSYNC_POL;
      blank_s1_reg <= 1'b1;
      fs_s1_reg    <= 1'b0;
    end else begin
      hsync_s1_reg <= hsync_s0;
      vsync_s1_reg <= vsync_s0;
      blank_s1_reg <= blank_s0;
      fs_s1_reg    <= fs_s0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [CH_W-1:0]  pat_h, pat_v;
  logic [PIX_W-1:0] pat_s0;
  logic [PIX_W-1:0] pat_s1_reg;
  pattern_e         pat_sel_s1_reg;

  assign pat_h = CH_W'(32'(hpos_reg) >> 4);
  assign pat_v = CH_W'(32'(vpos_reg) >> 4);

  // Stage-0 test pattern built from coarse raster coordinates.
  always_comb begin
    pat_s0 = '1;
    case (pattern_e'(pattern_sel))
      PAT_RED_GREEN: pat_s0 = PIX_W'({pat_v, pat_h, {CH_W{1'b0}}});
      PAT_RED_BLUE:  pat_s0 = PIX_W'({pat_v, {CH_W{1'b0}}, pat_h});
      default:       pat_s0 = '1;
    endcase
  end

  // Stage-1 pattern register so the pattern lines up with buffer data.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_s1_reg     <= '0;
      pat_sel_s1_reg <= PAT_BUFFER;
    end else begin
      pat_s1_reg     <= pat_s0;
      pat_sel_s1_reg <= pattern_e'(pattern_sel);
    end
  end

  // Stage-1 source select between buffer and pattern.
  always_comb begin
    pix_s1 = ram_rd_data;
    if (pat_sel_s1_reg != PAT_BUFFER) begin
      pix_s1 = pat_s1_reg;
    end
  end
`else
  assign pix_s1 = ram_rd_data;
`endif

  // Stage-2 control outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg <= ~HSYNC_POL;
      vsync_reg <= ~VSYNC_POL;
      blank_reg <= 1'b1;
      fs_reg    <= 1'b0;
    end else begin
      hsync_reg <= hsync_s1_reg;
      vsync_reg <= vsync_s1_reg;
      blank_reg <= blank_s1_reg;
      fs_reg    <= fs_s1_reg;
    end
  end

  // Stage-2 colour channels, red first; each is forced to zero while blanked.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [CH_W-1:0] chan_reg;

    // Per-channel output register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
        chan_reg <= '0;
      end else if (blank_s1_reg) begin
        chan_reg <= '0;
      end else begin
        chan_reg <= pix_s1[PIX_W-1-gi*CH_W -: CH_W];
      end
    end
  end

  assign vr          = g_chan[0].chan_reg;
  assign vg          = g_chan[1].chan_reg;
  assign vb          = g_chan[2].chan_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank       = blank_reg;
  assign frame_start = fs_reg;

endmodule
